// File: rtl/alu_operand_sequencer.sv
// Loads ALU operands A, B and opcode from a valid/ready byte stream, pulses the
// matching load strobes, waits ALU_LAT cycles and returns the result byte.
module alu_operand_sequencer #(
  parameter int msb     = 7,
  parameter int ALU_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [msb:0] rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [msb:0] buf_A,
  output logic [msb:0] buf_B,
  output logic [5:0]   buf_Op,
  output logic         p_a,
  output logic         p_b,
  output logic         p_c,
  input  logic [msb:0] alu_R,
  output logic [msb:0] tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_GET_A  = 3'd0,
    S_GET_B  = 3'd1,
    S_GET_OP = 3'd2,
    S_WAIT   = 3'd3,
    S_SEND   = 3'd4
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [msb:0] buf_a_q, buf_a_d;
  logic [msb:0] buf_b_q, buf_b_d;
  logic [5:0]   buf_op_q, buf_op_d;
  logic         p_a_q, p_a_d;
  logic         p_b_q, p_b_d;
  logic         p_c_q, p_c_d;
  logic [msb:0] tx_data_q, tx_data_d;
  logic         tx_valid_q, tx_valid_d;
  logic         rx_hs_s;

  assign rx_ready = rst_n && ((state_q == S_GET_A) || (state_q == S_GET_B) ||
                              (state_q == S_GET_OP));
  assign rx_hs_s  = rx_valid && rx_ready;

  // Next-state and datapath decode; strobes default low so they last one cycle
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_a_d    = buf_a_q;
    buf_b_d    = buf_b_q;
    buf_op_d   = buf_op_q;
    p_a_d      = 1'b0;
    p_b_d      = 1'b0;
    p_c_d      = 1'b0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      S_GET_A: begin
        if (rx_hs_s) begin
          buf_a_d = rx_data;
          p_a_d   = 1'b1;
          state_d = S_GET_B;
        end else begin
          state_d = S_GET_A;
        end
      end
      S_GET_B: begin
        if (rx_hs_s) begin
          buf_b_d = rx_data;
          p_b_d   = 1'b1;
          state_d = S_GET_OP;
        end else begin
          state_d = S_GET_B;
        end
      end
      S_GET_OP: begin
        if (rx_hs_s) begin
          buf_op_d = rx_data[5:0];
          p_c_d    = 1'b1;
          cnt_d    = 4'd0;
          state_d  = S_WAIT;
        end else begin
          state_d = S_GET_OP;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAT_M1) begin
          tx_data_d  = alu_R;
          tx_valid_d = 1'b1;
          state_d    = S_SEND;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_GET_A;
        end else begin
          state_d = S_SEND;
        end
      end
      default: begin
        state_d    = S_GET_A;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_GET_A;
      cnt_q      <= 4'd0;
      buf_a_q    <= '0;
      buf_b_q    <= '0;
      buf_op_q   <= 6'd0;
      p_a_q      <= 1'b0;
      p_b_q      <= 1'b0;
      p_c_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_a_q    <= buf_a_d;
      buf_b_q    <= buf_b_d;
      buf_op_q   <= buf_op_d;
      p_a_q      <= p_a_d;
      p_b_q      <= p_b_d;
      p_c_q      <= p_c_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign buf_A    = buf_a_q;
  assign buf_B    = buf_b_q;
  assign buf_Op   = buf_op_q;
  assign p_a      = p_a_q;
  assign p_b      = p_b_q;
  assign p_c      = p_c_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != S_GET_A);

endmodule
